// File: rtl/rc5_pkg.sv
// Shared RC5-16 types and constants for the key-schedule engine and its consumers.
package rc5_pkg;

    typedef logic [15:0] word_t;

    // Magic constants for 16-bit words: Odd((e-2)*2^16) and Odd((phi-1)*2^16)
    localparam word_t P16 = 16'hB7E1;
    localparam word_t Q16 = 16'h9E37;

    localparam int MAX_ROUNDS  = 16;
    localparam int NUM_SUBKEYS = 2 * (MAX_ROUNDS + 1);

    // Counter width wide enough for the largest mix count, 3*34 = 102
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_MIX,
        ST_DONE
    } state_t;

    // Round counts above the supported maximum saturate rather than wrap
    function automatic logic [4:0] clamp_rounds(input logic [4:0] r);
        return (r > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : r;
    endfunction

endpackage

// File: rtl/rotl.sv
// 16-bit left rotate by a 0..15 amount, purely combinational.
module rotl
    import rc5_pkg::*;
(
    input  word_t       data_i,
    input  logic [3:0]  n_i,
    output word_t       data_o
);

    logic [31:0] w_dbl;

    // Shifting a doubled copy leaves the rotated word in the upper half
    assign w_dbl  = {data_i, data_i} << n_i;
    assign data_o = w_dbl[31:16];

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16 key schedule: expands a secret key into S[0:33] over INIT and MIX passes
// and holds the finished table, flagged by keys_valid, until the next request.
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int KEY_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*KEY_BYTES-1:0]  key,
    input  logic [4:0]              num_rounds,
    output word_t                   subkeys [NUM_SUBKEYS],
    output logic                    keys_valid,
    output logic                    busy
);

    localparam int C        = (KEY_BYTES + 1) / 2;
    localparam int PAD_BITS = 16 * C - 8 * KEY_BYTES;
    localparam int LIDX_W   = (C > 1) ? $clog2(C) : 1;

    state_t                 r_state;
    word_t                  r_s [NUM_SUBKEYS];
    word_t                  r_l [C];
    word_t                  r_a;
    word_t                  r_b;
    word_t                  r_init_word;
    logic [5:0]             r_i;
    logic [LIDX_W-1:0]      r_j;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_t;
    logic [CNT_W-1:0]       r_n;
    logic                   r_keys_valid;
    logic                   r_busy;

    logic [16*C-1:0]        w_key_pad;
    word_t                  w_key_words [C];
    logic [4:0]             w_rc;
    logic [CNT_W-1:0]       w_t;
    logic [CNT_W-1:0]       w_m;
    logic [CNT_W-1:0]       w_n;
    word_t                  w_a_sum;
    word_t                  w_a_new;
    word_t                  w_ab;
    word_t                  w_b_sum;
    word_t                  w_b_new;
    logic                   w_i_last;
    logic                   w_j_last;

    // An odd byte count leaves the top byte of the last key word zero
    generate
        if (PAD_BITS > 0) begin : g_pad
            assign w_key_pad = {{PAD_BITS{1'b0}}, key};
        end else begin : g_nopad
            assign w_key_pad = key;
        end
    endgenerate

    // Little-endian packing: L[i] = {byte 2i+1, byte 2i}
    generate
        for (genvar gi = 0; gi < C; gi++) begin : g_key_words
            assign w_key_words[gi] = w_key_pad[16*gi +: 16];
        end
    endgenerate

    // t = 2*(r+1) and N = 3*max(t, C); the x3 is a shift-add
    assign w_rc = clamp_rounds(num_rounds);
    assign w_t  = {1'b0, w_rc, 1'b0} + 7'd2;
    assign w_m  = (w_t > 7'(C)) ? w_t : 7'(C);
    assign w_n  = w_m + {w_m[CNT_W-2:0], 1'b0};

    // One mixing step: A-path rotates by 3, B-path by the low nibble of A'+B
    assign w_a_sum = r_s[r_i] + r_a + r_b;
    assign w_ab    = w_a_new + r_b;
    assign w_b_sum = r_l[r_j] + w_ab;

    rotl u_rotl_a (
        .data_i (w_a_sum),
        .n_i    (4'd3),
        .data_o (w_a_new)
    );

    rotl u_rotl_b (
        .data_i (w_b_sum),
        .n_i    (w_ab[3:0]),
        .data_o (w_b_new)
    );

    assign w_i_last = ({1'b0, r_i} == (r_t - 7'd1));
    assign w_j_last = (r_j == LIDX_W'(C - 1));

    // Sequencer and datapath: latch on start, fill S, mix, then hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            for (int k = 0; k < NUM_SUBKEYS; k++) r_s[k] <= '0;
            for (int k = 0; k < C; k++) r_l[k] <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_init_word  <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_cnt        <= '0;
            r_t          <= '0;
            r_n          <= '0;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        for (int k = 0; k < C; k++) r_l[k] <= w_key_words[k];
                        for (int k = 0; k < NUM_SUBKEYS; k++) r_s[k] <= '0;
                        r_t          <= w_t;
                        r_n          <= w_n;
                        r_init_word  <= P16;
                        r_cnt        <= '0;
                        r_keys_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    r_s[r_cnt[5:0]] <= r_init_word;
                    r_init_word     <= r_init_word + Q16;
                    if (r_cnt == r_t - 7'd1) begin
                        r_a     <= '0;
                        r_b     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_MIX;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                ST_MIX: begin
                    // After the last iteration one extra cycle passes before
                    // the table is flagged, so latency is 1 + t + N edges
                    if (r_cnt == r_n) begin
                        r_keys_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_s[r_i] <= w_a_new;
                        r_l[r_j] <= w_b_new;
                        r_a      <= w_a_new;
                        r_b      <= w_b_new;
                        r_i      <= w_i_last ? 6'd0 : r_i + 6'd1;
                        r_j      <= w_j_last ? '0 : r_j + LIDX_W'(1);
                        r_cnt    <= r_cnt + 7'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The table is exposed live; consumers must gate on keys_valid
    generate
        for (genvar gi = 0; gi < NUM_SUBKEYS; gi++) begin : g_out
            assign subkeys[gi] = r_s[gi];
        end
    endgenerate

    assign keys_valid = r_keys_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for the RC5-16 key schedule with a reference expansion model.
module tb_rc5_key_expand;
    import rc5_pkg::*;

    localparam logic [127:0] KEY_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;

    logic           clk;
    logic           rst;
    logic           start;
    logic [127:0]   key;
    logic [4:0]     num_rounds;
    word_t          subkeys [NUM_SUBKEYS];
    logic           keys_valid;
    logic           busy;

    int             n_checks;
    int             n_errors;
    word_t          exp_s [NUM_SUBKEYS];
    word_t          tbl   [NUM_SUBKEYS];

    rc5_key_expand #(.KEY_BYTES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .num_rounds (num_rounds),
        .subkeys    (subkeys),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic word_t rotl16(input word_t x, input int n);
        int m;
        m = n & 15;
        return word_t'((x << m) | (x >> (16 - m)));
    endfunction

    function automatic word_t rotr16(input word_t x, input int n);
        return rotl16(x, (16 - (n & 15)) & 15);
    endfunction

    // Textbook RC5 key schedule with modulo indexing and a direct P+k*Q fill
    task automatic model_expand(input logic [127:0] k, input int rc);
        word_t L [8];
        word_t A, B, sum;
        int t, c, n, i, j;
        c = 8;
        t = 2 * (rc + 1);
        for (int s = 0; s < NUM_SUBKEYS; s++) exp_s[s] = 16'h0000;
        for (int s = 0; s < t; s++) exp_s[s] = word_t'(32'(P16) + 32'(s) * 32'(Q16));
        for (int x = 0; x < c; x++) L[x] = k[16*x +: 16];
        n = 3 * ((t > c) ? t : c);
        A = 0; B = 0; i = 0; j = 0;
        for (int it = 0; it < n; it++) begin
            A = rotl16(word_t'(exp_s[i] + A + B), 3);
            exp_s[i] = A;
            sum = word_t'(A + B);
            B = rotl16(word_t'(L[j] + sum), int'(sum[3:0]));
            L[j] = B;
            i = (i + 1) % t;
            j = (j + 1) % c;
        end
    endtask

    task automatic rc5_enc(input logic [31:0] pt, input int r, output logic [31:0] ct);
        word_t A, B;
        A = word_t'(pt[15:0] + tbl[0]);
        B = word_t'(pt[31:16] + tbl[1]);
        for (int i = 1; i <= r; i++) begin
            A = word_t'(rotl16(A ^ B, int'(B[3:0])) + tbl[2*i]);
            B = word_t'(rotl16(B ^ A, int'(A[3:0])) + tbl[2*i+1]);
        end
        ct = {B, A};
    endtask

    task automatic rc5_dec(input logic [31:0] ct, input int r, output logic [31:0] pt);
        word_t A, B;
        A = ct[15:0];
        B = ct[31:16];
        for (int i = r; i >= 1; i--) begin
            B = rotr16(word_t'(B - tbl[2*i+1]), int'(A[3:0])) ^ A;
            A = rotr16(word_t'(A - tbl[2*i]), int'(B[3:0])) ^ B;
        end
        B = word_t'(B - tbl[1]);
        A = word_t'(A - tbl[0]);
        pt = {B, A};
    endtask

    // One expansion; optionally fires a stray start pulse at a given edge count
    task automatic run_expand(input logic [127:0] k, input logic [4:0] r,
                              input int exp_lat, input int pulse_at, input string tag);
        int cnt;
        int rc;
        bit done;
        @(negedge clk);
        key        = k;
        num_rounds = r;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("%s_busy_rise", tag), 32'(busy), 32'd1);
        chk($sformatf("%s_valid_drop", tag), 32'(keys_valid), 32'd0);
        chk($sformatf("%s_s0_cleared", tag), 32'(subkeys[0]), 32'h0);
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (start) start = 1'b0;
            if (cnt == 1) chk($sformatf("%s_init_s0", tag), 32'(subkeys[0]), 32'hB7E1);
            if (cnt == 2) chk($sformatf("%s_init_s1", tag), 32'(subkeys[1]), 32'h5618);
            if (pulse_at > 0 && cnt == pulse_at) begin
                start      = 1'b1;
                key        = ~k;
                num_rounds = 5'd3;
            end
            if (keys_valid) done = 1'b1;
        end
        chk($sformatf("%s_latency", tag), 32'(cnt), 32'(exp_lat));
        chk($sformatf("%s_busy_fall", tag), 32'(busy), 32'd0);
        rc = (r > 5'd16) ? 16 : int'(r);
        model_expand(k, rc);
        for (int s = 0; s < NUM_SUBKEYS; s++)
            chk($sformatf("%s_S%0d", tag, s), 32'(subkeys[s]), 32'(exp_s[s]));
        $display("expand %s: r=%0d latency=%0d S[0]=0x%04h S[1]=0x%04h",
                 tag, r, cnt, subkeys[0], subkeys[1]);
    endtask

    initial begin
        logic [31:0] ct_dut, ct_ref, pt_back;
        bit any_nz;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        key        = '0;
        num_rounds = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle without start: everything stays cleared
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            any_nz = 1'b0;
            for (int s = 0; s < NUM_SUBKEYS; s++) if (subkeys[s] != 16'h0) any_nz = 1'b1;
            chk($sformatf("idle_c%0d", c), {29'd0, keys_valid, busy, any_nz}, 32'd0);
        end
        $display("idle: 50 cycles observed");

        // t=2, C=8, N=24 -> 27 edges
        run_expand(128'h0, 5'd0, 27, 0, "zero_r0");
        // t=26, N=78 -> 105 edges
        run_expand(KEY_SEQ, 5'd12, 105, 0, "seq_r12");
        // Stray start during MIX iteration 10 is ignored
        run_expand(KEY_SEQ, 5'd12, 105, 26 + 10, "seq_r12_pulse");
        // r=31 clamps to 16: t=34, N=102 -> 137 edges
        run_expand(KEY_SEQ, 5'd31, 137, 0, "seq_r31");

        // Round trip through an RC5-16 cipher using the expanded table
        run_expand(KEY_SEQ, 5'd12, 105, 0, "seq_r12_rt");
        for (int s = 0; s < NUM_SUBKEYS; s++) tbl[s] = subkeys[s];
        rc5_enc(32'h12345678, 12, ct_dut);
        rc5_dec(ct_dut, 12, pt_back);
        for (int s = 0; s < NUM_SUBKEYS; s++) tbl[s] = exp_s[s];
        rc5_enc(32'h12345678, 12, ct_ref);
        chk("rt_ciphertext", ct_dut, ct_ref);
        chk("rt_recovered", pt_back, 32'h12345678);
        $display("roundtrip: ct=0x%08h recovered=0x%08h", ct_dut, pt_back);

        // Reset in the middle of MIX aborts to the cleared state
        @(negedge clk);
        key        = KEY_SEQ;
        num_rounds = 5'd12;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        any_nz = 1'b0;
        for (int s = 0; s < NUM_SUBKEYS; s++) if (subkeys[s] != 16'h0) any_nz = 1'b1;
        chk("mid_rst_subkeys", 32'(any_nz), 32'd0);
        chk("mid_rst_valid", 32'(keys_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        $display("reset mid-MIX: valid=%0d busy=%0d", keys_valid, busy);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
RC5-16 key-schedule engine (16-bit words, 32-bit block). It expands a user secret key into the subkey table S[0:33] that feeds the encrypt/decrypt datapath, so it sits directly upstream of the algo core. It runs the standard RC5 initialisation and mixing passes as a multi-cycle sequential process. It signals when the table is valid and holds it stable until the next expansion request.

Parameters:
KEY_BYTES, 16, secret key length in bytes (1..32); C = max(1, ceil(KEY_BYTES/2)) key words.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request an expansion; sampled on the rising edge
key  in  8*KEY_BYTES  secret key; byte k is key[8k+7:8k]; little-endian word packing L[i] = {byte 2i+1, byte 2i}
num_rounds  in  5  round count r, non-zero-indexed; values >16 clamp to 16
subkeys  out  34x16  S[0:33] table (unpacked array, same shape as the algo input)
keys_valid  out  1  table complete and stable
busy  out  1  expansion in progress

Behaviour:
- Reset: state IDLE; all subkeys = 0; keys_valid = 0; busy = 0; internal L[], A, B, i, j and counter = 0. Reset mid-expansion aborts it and gives the same values.
- t = 2*(r_clamped+1), so t ranges 2..34. N = 3*max(t, C) mix iterations.
- States: IDLE, INIT, MIX, DONE.
- IDLE/DONE with start=1: latch key into L[0:C-1], latch r_clamped, clear all S to 0, set keys_valid=0, busy=1, counter=0, go to INIT. Odd KEY_BYTES zero-pads the top byte of L[C-1].
- INIT: write one entry per cycle, S[k] = P16 + k*Q16 (mod 2^16) for k = 0..t-1, with P16=0xB7E1 and Q16=0x9E37. Compute it incrementally (S[k] = S[k-1] + Q16); no multiplier. After t cycles, clear A, B, i, j and counter, then go to MIX.
- MIX: one iteration per cycle.
  - A' = rotl(S[i] + A + B, 3); S[i] = A'.
  - B' = rotl(L[j] + A' + B, (A' + B)[3:0]); L[j] = B'.
  - i = (i+1) mod t; j = (j+1) mod C. Wrap uses compare-and-clear; no divider.
  - After N iterations, go to DONE.
- DONE: keys_valid=1, busy=0. The table is held until start or rst.
- Entries S[t..33] remain 0 after expansion.
- start while busy (INIT/MIX) is ignored. key and num_rounds changes during busy have no effect, because values are latched at start.
- start in DONE restarts the expansion: keys_valid drops on the next edge.
- Latency: keys_valid rises exactly 1 + t + N clock edges after the edge that samples start.
  - Example: KEY_BYTES=16, r=12 gives t=26, N=78, latency 105.
- Arithmetic is 16-bit modular throughout; rotation amount is mod 16.
- subkeys is driven directly from the S registers, so intermediate values are visible while busy. Consumers must gate on keys_valid.

Decomposition:
- Shared package rc5_pkg holds:
  - word_t (16-bit);
  - P16, Q16;
  - MAX_ROUNDS = 16;
  - NUM_SUBKEYS = 34;
  - the state enum.
- The existing rotl module (data_i, n_i, data_o) is instantiated twice: once for the A-path with fixed amount 3, once for the B-path with a variable amount.
- No other sub-module.

Test Plan:
- Reset then idle, no start: all 34 subkeys = 0x0000, keys_valid=0, busy=0 for 50 cycles. Assert rst mid-MIX: the same values on the next edge.
- key=0, num_rounds=0 (t=2, C=8, N=24):
  - busy rises on the edge after start;
  - keys_valid rises exactly 27 edges after start;
  - S[0:1] match the golden C model;
  - S[2:33]=0.
- key=0x0F0E..0100 (bytes 0x00..0x0F), num_rounds=12: keys_valid after 105 edges; all 26 entries match the golden model.
- Pulse start again at iteration 10 of MIX with a different key: the pulse is ignored, and the result equals the first key's table.
- num_rounds=31: t clamps to 34, N=102, latency 137; S[0:33] all match the model for r=16.
- Round-trip: connect to algo, expand, encrypt d_in=0x12345678 with r=12, decrypt the result. Recovered data = 0x12345678, and the ciphertext matches the golden model.
